// File: rtl/product_bcd_converter_pkg.sv
// Shared constants and FSM encoding for the product-to-BCD readout converter.
package product_bcd_converter_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DIGITS_DEF = 5;
    localparam int CNT_W      = $clog2(WIDTH_DEF + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Multiplier-result capture and BCD readout signals between multiplier, converter and display.
interface product_bcd_converter_if
    import product_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
);

    logic [WIDTH-1:0]    product;
    logic                sign;
    logic                done;
    logic [4*DIGITS-1:0] bcd_digits;
    logic                neg;
    logic                valid;
    logic                busy;

    modport master (
        output product, sign, done,
        input  bcd_digits, neg, valid, busy
    );

    modport slave (
        input  product, sign, done,
        output bcd_digits, neg, valid, busy
    );

endinterface

// File: rtl/product_bcd_converter_bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
// Latency: combinational. Backpressure: none.
// No carry out; the caller guarantees the input is a valid BCD digit.
module product_bcd_converter_bcd_digit_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/product_bcd_converter.sv
// Converts a captured sign-magnitude product to packed BCD, one double-dabble bit per cycle.
// Latency: valid pulses the cycle after the WIDTH-th shift edge (17 edges after start for WIDTH=16).
// Backpressure: none; done edges arriving while busy are dropped, not queued.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    product_bcd_converter_if.slave  bus
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH == WIDTH_DEF) ? CNT_W : $clog2(WIDTH + 1);

    state_t          state_q;
    state_t          state_nxt;
    logic            done_d;
    logic            start;
    logic            load;
    logic            step;
    logic            finish;
    logic            last;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]   bcd_q;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_shift;
    logic [CW-1:0]   cnt_q;
    logic            sign_q;
    logic [BW-1:0]   digits_q;
    logic            neg_q;
    logic            valid_q;

    assign start = bus.done && !done_d;
    assign last  = (cnt_q == CW'(WIDTH - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        product_bcd_converter_bcd_digit_adjust u_adj (
            .din  (bcd_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    // Binary MSB shifts into BCD bit 0 after all digits have been corrected.
    assign bcd_shift = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_d   <= 1'b0;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            digits_q <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            done_d  <= bus.done;
            valid_q <= finish;
            if (load) begin
                bin_q  <= bus.product;
                sign_q <= bus.sign;
                bcd_q  <= '0;
                cnt_q  <= '0;
            end else if (step) begin
                bin_q <= {bin_q[WIDTH-2:0], 1'b0};
                bcd_q <= bcd_shift;
                cnt_q <= cnt_q + CW'(1);
            end
            // A zero BCD result means a zero magnitude, so minus-zero is suppressed here.
            if (finish) begin
                digits_q <= bcd_shift;
                neg_q    <= sign_q && (bcd_shift != '0);
            end
        end
    end

    assign bus.bcd_digits = digits_q;
    assign bus.neg        = neg_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized and directed bench for product_bcd_converter against a decimal-arithmetic reference.
module tb_product_bcd_converter;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   cyc;
    int   valid_cnt;
    int   last_valid_cyc;

    product_bcd_converter_if bus ();

    product_bcd_converter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always begin
        @(posedge clk);
        #1;
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] d;
        int t;
        d = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            d[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raises done at the current negedge; done stays high for 'hold' sampled edges,
    // and an extra one-edge done pulse is issued at edge 'repulse' (0 = none).
    task automatic convert(input logic [15:0] p, input logic s, input int hold, input int repulse);
        logic [19:0] exp_d;
        logic        exp_n;
        int          v0;
        int          n;
        exp_d = ref_bcd(int'(p));
        exp_n = s && (p != 16'd0);
        v0    = valid_cnt;
        n     = (hold > 17) ? hold : 17;
        bus.product = p;
        bus.sign    = s;
        bus.done    = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus.done = (k < hold) || (k == repulse);
            if (k == repulse) bus.product = 16'($urandom);
            if (k == 1 || k == 8 || k == 16) check("busy_during", 32'(bus.busy), 32'd1);
            if (k == 16) check("valid_early", 32'(bus.valid), 32'd0);
            if (k == 17) begin
                check("valid_pulse", 32'(bus.valid), 32'd1);
                check("busy_done", 32'(bus.busy), 32'd0);
                check("bcd_digits", 32'(bus.bcd_digits), 32'(exp_d));
                check("neg", 32'(bus.neg), 32'(exp_n));
            end
        end
        check("valid_count", 32'(valid_cnt - v0), 32'd1);
    endtask

    initial begin
        int t1;
        logic [15:0] p;
        n_chk = 0;
        n_err = 0;
        cyc = 0;
        valid_cnt = 0;
        last_valid_cyc = 0;

        rst_n = 1'b0;
        bus.done = 1'b1;
        bus.product = 16'd4242;
        bus.sign = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_digits", 32'(bus.bcd_digits), 32'd0);
        check("rst_neg", 32'(bus.neg), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_no_valid", 32'(valid_cnt), 32'd0);
        bus.done = 1'b0;
        rst_n = 1'b1;
        idle(2);

        convert(16'd16384, 1'b1, 1, 0);
        idle(3);
        convert(16'd65535, 1'b0, 1, 0);
        idle(2);
        convert(16'd0, 1'b1, 1, 0);
        idle(2);
        convert(16'd9, 1'b0, 40, 0);
        idle(2);
        convert(16'd1234, 1'b0, 1, 8);
        idle(2);

        // Reset lands on edge E7 of a conversion of 4321.
        t1 = valid_cnt;
        bus.product = 16'd4321;
        bus.sign = 1'b0;
        bus.done = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.done = 1'b0;
            if (k == 7) rst_n = 1'b0;
        end
        @(negedge clk);
        check("midrst_digits", 32'(bus.bcd_digits), 32'd0);
        check("midrst_neg", 32'(bus.neg), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        rst_n = 1'b1;
        idle(20);
        check("midrst_no_valid", 32'(valid_cnt - t1), 32'd0);
        convert(16'd77, 1'b1, 1, 0);
        idle(2);

        convert(16'd4660, 1'b1, 1, 0);
        t1 = last_valid_cyc;
        convert(16'd999, 1'b0, 1, 0);
        check("b2b_gap", 32'(last_valid_cyc - t1), 32'd17);

        for (int i = 0; i < 25; i++) begin
            idle($urandom_range(0, 3));
            p = 16'($urandom);
            case ($urandom_range(0, 7))
                0: p = 16'd0;
                1: p = 16'hFFFF;
                default: ;
            endcase
            convert(p, 1'($urandom_range(0, 1)), $urandom_range(1, 4), 0);
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
